// File: rtl/rpspmc_sts_pkg.sv
// ---------------------------------------------------------------------------
// rpspmc_sts_pkg
// Shared definitions for the AXIS-to-status return path:
//   - sts_state_e   : control FSM states of axis_to_sts
//   - STS_WORD_BITS : width of the published status word
//   - sext_word()   : sign-extends the low src_bits of a word to full width
// ---------------------------------------------------------------------------
package rpspmc_sts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } sts_state_e;

    localparam int STS_WORD_BITS = 32;

    // Replicates bit (src_bits-1) into every bit above it.
    function automatic logic [STS_WORD_BITS-1:0] sext_word(
        input logic [STS_WORD_BITS-1:0] v,
        input int                       src_bits
    );
        logic [STS_WORD_BITS-1:0] r;
        for (int i = 0; i < STS_WORD_BITS; i++) begin
            r[i] = (i < src_bits) ? v[i] : v[src_bits-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/sts_accum.sv
// ---------------------------------------------------------------------------
// sts_accum
// Signed accumulate / count / shift datapath for one averaging block.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold accumulator and count at zero (outside a block)
//   add_en     : add 'sample' this cycle
//   sample     : signed input sample (SRC_BITS)
//   n          : averaging exponent, already clamped to AVG_LOG2_MAX
//   sum_avg    : registered average of the last completed block
//   last       : combinational; this add completes the block of 2^n samples
// ---------------------------------------------------------------------------
module sts_accum
    import rpspmc_sts_pkg::*;
#(
    parameter int SRC_BITS     = 32,
    parameter int AVG_LOG2_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       add_en,
    input  logic signed [SRC_BITS-1:0] sample,
    input  logic        [3:0]          n,
    output logic signed [SRC_BITS-1:0] sum_avg,
    output logic                       last
);

    // Headroom for 2^AVG_LOG2_MAX full-scale samples, so the sum never wraps.
    localparam int ACC_W = SRC_BITS + AVG_LOG2_MAX;
    localparam int CNT_W = AVG_LOG2_MAX + 1;

    logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic        [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic signed [SRC_BITS-1:0] avg_q, avg_d;

    always_comb begin
        acc_sum = acc_q + ACC_W'(sample);
        cnt_inc = cnt_q + CNT_W'(1);
        last    = add_en && (cnt_inc == (CNT_W'(1) << n));

        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;

        // The completing add clears the block state and captures the result,
        // so the next block can start from zero without an extra cycle.
        if (clr || last) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_en) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
        end

        // Arithmetic shift floors toward -inf; truncation back to SRC_BITS
        // is exact because |sum| <= 2^n * full scale.
        if (last) begin
            avg_d = SRC_BITS'(acc_sum >>> n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
        end
    end

    assign sum_avg = avg_q;

endmodule

// File: rtl/axis_to_sts.sv
// ---------------------------------------------------------------------------
// axis_to_sts
// Averages a signed S_AXIS sample stream over 2^N samples and publishes the
// result as a 32-bit status word, either continuously or once per toggle
// of the snapshot request.
// Ports:
//   a_clk, a_resetn          : clock, asynchronous active-low reset
//   S_AXIS_tdata/tvalid/ready: sample stream (tready high after reset)
//   cfg_mode                 : 0 = continuous, 1 = snapshot
//   cfg_avg_log2             : averaging exponent N (clamped)
//   cfg_snap_req             : snapshot request toggle
//   sts_word                 : last published average, sign-extended
//   sts_seq                  : publish counter (wraps)
//   sts_snap_ack             : copy of the last served snapshot request
//   sts_busy                 : high while a block is accumulating
// ---------------------------------------------------------------------------
module axis_to_sts
    import rpspmc_sts_pkg::*;
#(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int SRC_BITS          = 32,
    parameter int AVG_LOG2_MAX      = 8
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    input  logic                         cfg_mode,
    input  logic [3:0]                   cfg_avg_log2,
    input  logic                         cfg_snap_req,
    output logic [31:0]                  sts_word,
    output logic [15:0]                  sts_seq,
    output logic                         sts_snap_ack,
    output logic                         sts_busy
);

    localparam logic [3:0] N_MAX = 4'(AVG_LOG2_MAX);

    sts_state_e                 state_q, state_d;
    logic                       tready_q;
    logic [3:0]                 n_lat_q, n_lat_d;
    logic                       mode_lat_q, mode_lat_d;
    logic                       req_lat_q, req_lat_d;
    logic [STS_WORD_BITS-1:0]   word_q, word_d;
    logic [15:0]                seq_q, seq_d;
    logic                       ack_q, ack_d;
    logic                       busy_q, busy_d;

    logic                       add_en, acc_clr, acc_last;
    logic signed [SRC_BITS-1:0] sample, avg;
    logic [STS_WORD_BITS-1:0]   avg_word;

    assign sample  = S_AXIS_tdata[SRC_BITS-1:0];
    // Samples offered outside ACCUM are consumed (tready stays high) but dropped.
    assign add_en  = (state_q == ST_ACCUM) && S_AXIS_tvalid && tready_q;
    assign acc_clr = (state_q != ST_ACCUM);

    if (SRC_BITS < SAXIS_TDATA_WIDTH) begin : g_unused_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^S_AXIS_tdata[SAXIS_TDATA_WIDTH-1:SRC_BITS];
    end

    sts_accum #(
        .SRC_BITS     (SRC_BITS),
        .AVG_LOG2_MAX (AVG_LOG2_MAX)
    ) u_accum (
        .clk     (a_clk),
        .rst_n   (a_resetn),
        .clr     (acc_clr),
        .add_en  (add_en),
        .sample  (sample),
        .n       (n_lat_q),
        .sum_avg (avg),
        .last    (acc_last)
    );

    always_comb begin
        avg_word                = '0;
        avg_word[SRC_BITS-1:0]  = avg;

        state_d    = state_q;
        n_lat_d    = n_lat_q;
        mode_lat_d = mode_lat_q;
        req_lat_d  = req_lat_q;
        word_d     = word_q;
        seq_d      = seq_q;
        ack_d      = ack_q;

        case (state_q)
            ST_IDLE: begin
                // Block configuration tracks the inputs while idle and is
                // frozen once ACCUM is entered.
                n_lat_d    = (cfg_avg_log2 > N_MAX) ? N_MAX : cfg_avg_log2;
                mode_lat_d = cfg_mode;
                if (!cfg_mode) begin
                    state_d = ST_ACCUM;
                end else if (cfg_snap_req != ack_q) begin
                    state_d   = ST_ACCUM;
                    req_lat_d = cfg_snap_req;
                end
            end
            ST_ACCUM: begin
                if (acc_last) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                word_d = sext_word(avg_word, SRC_BITS);
                seq_d  = seq_q + 16'd1;
                if (mode_lat_q) begin
                    ack_d = req_lat_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ACCUM);
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q    <= ST_IDLE;
            tready_q   <= 1'b0;
            n_lat_q    <= '0;
            mode_lat_q <= 1'b0;
            req_lat_q  <= 1'b0;
            word_q     <= '0;
            seq_q      <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tready_q   <= 1'b1;
            n_lat_q    <= n_lat_d;
            mode_lat_q <= mode_lat_d;
            req_lat_q  <= req_lat_d;
            word_q     <= word_d;
            seq_q      <= seq_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign S_AXIS_tready = tready_q;
    assign sts_word      = word_q;
    assign sts_seq       = seq_q;
    assign sts_snap_ack  = ack_q;
    assign sts_busy      = busy_q;

endmodule

// File: tb/tb_axis_to_sts.sv
// ---------------------------------------------------------------------------
// tb_axis_to_sts
// Self-checking bench for axis_to_sts (SRC_BITS = 16 inside 32-bit tdata).
// A block-level reference model collects accepted samples in a queue and
// computes the expected average with plain integer arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_to_sts;

    localparam int TDW  = 32;
    localparam int SRC  = 16;
    localparam int NMAX = 8;

    logic           a_clk = 1'b0;
    logic           a_resetn = 1'b0;
    logic [TDW-1:0] S_AXIS_tdata = '0;
    logic           S_AXIS_tvalid = 1'b0;
    logic           S_AXIS_tready;
    logic           cfg_mode = 1'b0;
    logic [3:0]     cfg_avg_log2 = 4'd0;
    logic           cfg_snap_req = 1'b0;
    logic [31:0]    sts_word;
    logic [15:0]    sts_seq;
    logic           sts_snap_ack;
    logic           sts_busy;

    always #5 a_clk = ~a_clk;

    axis_to_sts #(
        .SAXIS_TDATA_WIDTH (TDW),
        .SRC_BITS          (SRC),
        .AVG_LOG2_MAX      (NMAX)
    ) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .cfg_mode      (cfg_mode),
        .cfg_avg_log2  (cfg_avg_log2),
        .cfg_snap_req  (cfg_snap_req),
        .sts_word      (sts_word),
        .sts_seq       (sts_seq),
        .sts_snap_ack  (sts_snap_ack),
        .sts_busy      (sts_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_in_block, m_pend, m_mode, m_req;
    int          m_n;
    longint      m_q[$];
    logic [31:0] m_word, m_pend_word;
    logic [15:0] m_seq;
    logic        m_ack, m_tready;

    bit gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_block = 1'b0;
        m_pend     = 1'b0;
        m_mode     = 1'b0;
        m_req      = 1'b0;
        m_n        = 0;
        m_q.delete();
        m_word     = '0;
        m_seq      = '0;
        m_ack      = 1'b0;
        m_tready   = 1'b0;
    endfunction

    // One clock edge of the block-level behaviour, using the inputs present at the edge.
    function automatic void model_step();
        m_tready = 1'b1;
        if (m_in_block) begin
            if (S_AXIS_tvalid) begin
                m_q.push_back(longint'($signed(S_AXIS_tdata[SRC-1:0])));
                if (m_q.size() == (1 << m_n)) begin
                    longint     s;
                    logic [15:0] w16;
                    s = 0;
                    foreach (m_q[i]) s += m_q[i];
                    s = s >>> m_n;
                    w16 = s[15:0];
                    m_pend_word = {{16{w16[15]}}, w16};
                    m_q.delete();
                    m_in_block = 1'b0;
                    m_pend     = 1'b1;
                end
            end
        end else if (m_pend) begin
            m_word = m_pend_word;
            m_seq  = m_seq + 16'd1;
            if (m_mode) m_ack = m_req;
            m_pend = 1'b0;
        end else if (!cfg_mode || (cfg_snap_req != m_ack)) begin
            m_in_block = 1'b1;
            m_mode     = cfg_mode;
            m_req      = cfg_snap_req;
            m_n        = (cfg_avg_log2 > NMAX) ? NMAX : int'(cfg_avg_log2);
        end
    endfunction

    task automatic compare_all();
        check("tready", 32'(S_AXIS_tready), 32'(m_tready));
        check("word",   sts_word,           m_word);
        check("seq",    32'(sts_seq),       32'(m_seq));
        check("ack",    32'(sts_snap_ack),  32'(m_ack));
        check("busy",   32'(sts_busy),      32'(m_in_block));
    endtask

    task automatic cyc(input logic v, input logic [15:0] d);
        S_AXIS_tvalid = v;
        S_AXIS_tdata  = {16'($urandom()), d};
        @(posedge a_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        a_resetn      = 1'b0;
        S_AXIS_tvalid = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge a_clk);
        #1;
        compare_all();
        a_resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_mode     = 1'b0;
        cfg_avg_log2 = 4'd2;
        cfg_snap_req = 1'b0;
        #1;
        apply_reset();

        // Continuous, N=2: 4 + 8 - 4 + 0 = 8, /4 = 2
        cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h0004);
        cyc(1'b1, 16'h0008);
        cyc(1'b1, 16'hFFFC);
        cyc(1'b1, 16'h0000);
        check("t1_seq_before", 32'(sts_seq), 32'd0);
        cfg_avg_log2 = 4'd1;
        cyc(1'b0, 16'h0000);
        check("t1_word", sts_word, 32'h0000_0002);
        check("t1_seq",  32'(sts_seq), 32'd1);

        // Negative floor, N=1: (-3 + -2) >>> 1 = -3
        cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'hFFFD);
        cyc(1'b1, 16'hFFFE);
        cyc(1'b0, 16'h0000);
        check("t2_word", sts_word, 32'hFFFF_FFFD);
        check("t2_seq",  32'(sts_seq), 32'd2);

        // Randomized: mode flips, request toggles, exponent changes incl. clamped values
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) cfg_mode = ~cfg_mode;
            if ($urandom_range(0, 99) < 6) cfg_snap_req = ~cfg_snap_req;
            if ($urandom_range(0, 99) < 5)
                cfg_avg_log2 = ($urandom_range(0, 19) == 0) ? 4'(9 + $urandom_range(0, 6))
                                                            : 4'($urandom_range(0, 4));
            cyc($urandom_range(0, 99) < 70, 16'($urandom()));
        end

        // Snapshot, N=0: nothing without a toggle, exactly one publish per toggle
        cfg_mode     = 1'b1;
        cfg_avg_log2 = 4'd0;
        cfg_snap_req = 1'b0;
        apply_reset();
        repeat (20) cyc(1'b1, 16'h1234);
        check("snap_idle_seq",  32'(sts_seq), 32'd0);
        check("snap_idle_busy", 32'(sts_busy), 32'd0);
        cfg_snap_req = 1'b1;
        repeat (3) cyc(1'b1, 16'h1234);
        check("snap_word", sts_word, 32'h0000_1234);
        check("snap_ack",  32'(sts_snap_ack), 32'd1);
        check("snap_seq",  32'(sts_seq), 32'd1);
        repeat (20) cyc(1'b1, 16'h1234);
        check("snap_hold_seq", 32'(sts_seq), 32'd1);

        // Clamp: N=15 behaves as N=8, publish after exactly 256 samples
        cfg_mode     = 1'b0;
        cfg_avg_log2 = 4'd15;
        apply_reset();
        repeat (257) cyc(1'b1, 16'($urandom()));
        check("clamp_seq_256", 32'(sts_seq), 32'd0);
        cyc(1'b1, 16'($urandom()));
        check("clamp_seq_pub", 32'(sts_seq), 32'd1);

        // Reset in the middle of a block
        cfg_avg_log2 = 4'd3;
        apply_reset();
        cyc(1'b0, 16'h0000);
        repeat (8) cyc(1'b1, 16'h0100);
        cyc(1'b0, 16'h0000);
        check("mid_pre_word", sts_word, 32'h0000_0100);
        cyc(1'b0, 16'h0000);
        repeat (5) cyc(1'b1, 16'($urandom()));
        check("mid_busy", 32'(sts_busy), 32'd1);
        #3;
        a_resetn = 1'b0;
        model_reset();
        #1;
        check("mid_rst_word",   sts_word, 32'd0);
        check("mid_rst_seq",    32'(sts_seq), 32'd0);
        check("mid_rst_ack",    32'(sts_snap_ack), 32'd0);
        check("mid_rst_busy",   32'(sts_busy), 32'd0);
        check("mid_rst_tready", 32'(S_AXIS_tready), 32'd0);
        @(posedge a_clk);
        #1;
        a_resetn = 1'b1;
        cyc(1'b0, 16'h0000);
        repeat (8) cyc(1'b1, 16'($urandom()));
        check("mid_fresh_seq0", 32'(sts_seq), 32'd0);
        cyc(1'b0, 16'h0000);
        check("mid_fresh_seq1", 32'(sts_seq), 32'd1);

        // tvalid gaps, N=2: one publish after the 4th valid sample
        cfg_avg_log2 = 4'd2;
        apply_reset();
        cyc(1'b0, 16'h0000);
        for (int k = 0; k < 7; k++) begin
            cyc(gap_pat[k], 16'($urandom()));
            if (k < 6) check("gap_busy", 32'(sts_busy), 32'd1);
        end
        check("gap_busy_end", 32'(sts_busy), 32'd0);
        check("gap_seq0",     32'(sts_seq), 32'd0);
        cyc(1'b0, 16'h0000);
        check("gap_seq1", 32'(sts_seq), 32'd1);
        repeat (10) cyc(1'b0, 16'h0000);
        check("gap_seq_hold", 32'(sts_seq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
